// File: rtl/rx_frame_unpack.sv
// UART receive frame unpacker: assembles start/data/parity/stop samples into a right-justified word.
// Latency: word visible on rx_data with rx_valid=1 right after the final stop-bit strobe edge.
// Backpressure: rx_valid/rx_ready; a commit into a full output stage with no same-edge pop drops the frame and sets overrun.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   bit_stb, bit_in       mid-bit sample strobe and sampled line value
//   data_len, pen, ohel,  frame format (clamped length 5..MAX_DATA_W, parity enable,
//   two_stop              odd parity select, two stop bits); latched at the start bit
//   rx_ready, clr_ovf     consumer pop, sticky overrun clear
//   rx_data, rx_valid,    head word, its valid flag and parity/framing error flags
//   rx_perr, rx_ferr
//   overrun, busy         sticky overrun flag, frame in progress
//
// Build option: define RX_UNPACK_FIFO_EN to replace the single holding register with a
// first-word-fall-through FIFO of FIFO_DEPTH entries.
module rx_frame_unpack #(
  parameter int MAX_DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_stb,
  input  logic                  bit_in,
  input  logic [3:0]            data_len,
  input  logic                  pen,
  input  logic                  ohel,
  input  logic                  two_stop,
  input  logic                  rx_ready,
  input  logic                  clr_ovf,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_perr,
  output logic                  rx_ferr,
  output logic                  overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_W);

  state_t                state_q;
  logic [3:0]            bit_cnt_q;
  logic [MAX_DATA_W-1:0] shreg_q;
  logic [3:0]            len_q;
  logic                  pen_q;
  logic                  ohel_q;
  logic                  two_stop_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  stop2_q;    // first of two stop bits already sampled
  logic                  ovf_q;

  logic [3:0]            len_eff;
  logic                  commit;
  logic                  cm_ferr;
  logic                  ovf_set;

  // Out-of-range lengths saturate to the legal window.
  always_comb begin
    len_eff = data_len;
    if (data_len < 4'd5)
      len_eff = 4'd5;
    else if (data_len > MAX_LEN)
      len_eff = MAX_LEN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      len_q      <= 4'd5;
      pen_q      <= 1'b0;
      ohel_q     <= 1'b0;
      two_stop_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (bit_stb) begin
      case (state_q)
        S_IDLE: begin
          if (!bit_in) begin
            state_q    <= S_DATA;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;   // keeps unused upper bits zero for short frames
            len_q      <= len_eff;
            pen_q      <= pen;
            ohel_q     <= ohel;
            two_stop_q <= two_stop;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop2_q    <= 1'b0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < MAX_DATA_W; i++) begin
            if (bit_cnt_q == i[3:0])
              shreg_q[i] <= bit_in;
          end
          if (bit_cnt_q == len_q - 4'd1) begin
            bit_cnt_q <= '0;
            state_q   <= pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_PARITY: begin
          // Upper bits are zero, so reducing the whole register gives the data parity.
          perr_q  <= bit_in != ((^shreg_q) ^ ohel_q);
          state_q <= S_STOP;
        end
        S_STOP: begin
          if (!bit_in)
            ferr_q <= 1'b1;
          if (two_stop_q && !stop2_q)
            stop2_q <= 1'b1;
          else
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The last stop strobe commits directly so the word lands on the same edge.
  assign commit  = bit_stb && (state_q == S_STOP) && (!two_stop_q || stop2_q);
  assign cm_ferr = ferr_q | ~bit_in;
  assign busy    = (state_q != S_IDLE);

`ifdef RX_UNPACK_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] dat;
    logic                  perr;
    logic                  ferr;
  } entry_t;

  entry_t      mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  entry_t      head;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop     = !empty && rx_ready;
  // A pop on the commit edge frees a slot for the incoming word.
  assign push    = commit && (!full || pop);
  assign ovf_set = commit && full && !rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= '{dat: shreg_q, perr: perr_q, ferr: cm_ferr};
  end

  assign head     = mem_q[rd_q];
  assign rx_valid = !empty;
  assign rx_data  = empty ? '0 : head.dat;
  assign rx_perr  = !empty && head.perr;
  assign rx_ferr  = !empty && head.ferr;
`else
  logic [MAX_DATA_W-1:0] out_dat_q;
  logic                  out_vld_q;
  logic                  out_perr_q;
  logic                  out_ferr_q;
  logic                  pop;

  assign pop     = out_vld_q && rx_ready;
  assign ovf_set = commit && out_vld_q && !rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_dat_q  <= '0;
      out_vld_q  <= 1'b0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
    end else begin
      if (pop)
        out_vld_q <= 1'b0;
      if (commit && (!out_vld_q || pop)) begin
        out_dat_q  <= shreg_q;
        out_perr_q <= perr_q;
        out_ferr_q <= cm_ferr;
        out_vld_q  <= 1'b1;
      end
    end
  end

  // FIFO_DEPTH only sizes the buffered build.
  if (FIFO_DEPTH < 2) begin : g_depth_unused
  end

  assign rx_valid = out_vld_q;
  assign rx_data  = out_dat_q;
  assign rx_perr  = out_perr_q;
  assign rx_ferr  = out_ferr_q;
`endif

  // A new overrun takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (ovf_set)
      ovf_q <= 1'b1;
    else if (clr_ovf)
      ovf_q <= 1'b0;
  end

  assign overrun = ovf_q;

endmodule

// File: tb/tb_rx_frame_unpack.sv
// Directed bench for rx_frame_unpack: frame formats, parity/framing flags, overrun and reset abort.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
// Output stage depth follows RX_UNPACK_FIFO_EN so one stimulus set covers both builds.
module tb_rx_frame_unpack;

  localparam int MAX_DATA_W = 8;
`ifdef RX_UNPACK_FIFO_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 1;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  bit_stb = 1'b0;
  logic                  bit_in = 1'b1;
  logic [3:0]            data_len = 4'd8;
  logic                  pen = 1'b0;
  logic                  ohel = 1'b0;
  logic                  two_stop = 1'b0;
  logic                  rx_ready = 1'b0;
  logic                  clr_ovf = 1'b0;
  logic [MAX_DATA_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_perr;
  logic                  rx_ferr;
  logic                  overrun;
  logic                  busy;

  int n_chk = 0;
  int n_err = 0;

  rx_frame_unpack #(.MAX_DATA_W(MAX_DATA_W), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_stb  (bit_stb),
    .bit_in   (bit_in),
    .data_len (data_len),
    .pen      (pen),
    .ohel     (ohel),
    .two_stop (two_stop),
    .rx_ready (rx_ready),
    .clr_ovf  (clr_ovf),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_perr  (rx_perr),
    .rx_ferr  (rx_ferr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One idle cycle, then a single-cycle strobe; optional pop/clear on the strobe edge.
  task automatic strobe(input logic b, input logic rdy, input logic clr);
    @(posedge clk); #1;
    bit_stb = 1'b1;
    bit_in  = b;
    if (rdy) rx_ready = 1'b1;
    if (clr) clr_ovf = 1'b1;
    @(posedge clk); #1;
    bit_stb = 1'b0;
    bit_in  = 1'b1;
    if (rdy) rx_ready = 1'b0;
    if (clr) clr_ovf = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] d, input int n, input logic do_par,
                            input logic par, input logic s1, input logic s2,
                            input logic two, input logic pop_last, input logic clr_last);
    strobe(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) strobe(d[i], 1'b0, 1'b0);
    if (do_par) strobe(par, 1'b0, 1'b0);
    if (two) begin
      strobe(s1, 1'b0, 1'b0);
      strobe(s2, pop_last, clr_last);
    end else begin
      strobe(s1, pop_last, clr_last);
    end
  endtask

  task automatic frame8(input logic [7:0] d, input logic pop_last, input logic clr_last);
    send_frame({1'b0, d}, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pop_last, clr_last);
  endtask

  // Check the head word, then pop it with a one-cycle rx_ready.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, rx_valid, 1);
    chk({tag, "_dat"}, rx_data, exp);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  logic [7:0] words [5];
  logic [7:0] a5;

  initial begin
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_vld", rx_valid, 0);
    chk("rst_dat", rx_data, 0);
    chk("rst_perr", rx_perr, 0);
    chk("rst_ferr", rx_ferr, 0);
    chk("rst_ovf", overrun, 0);
    chk("rst_busy", busy, 0);

    // Idle-line strobes are ignored
    strobe(1'b1, 1'b0, 1'b0);
    chk("idle_busy", busy, 0);

    // 8N1, 0xA5, with latency check
    data_len = 4'd8; pen = 1'b0; two_stop = 1'b0;
    a5 = 8'hA5;
    strobe(1'b0, 1'b0, 1'b0);
    chk("8n1_busy", busy, 1);
    for (int i = 0; i < 8; i++) strobe(a5[i], 1'b0, 1'b0);
    chk("8n1_pre_vld", rx_valid, 0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("8n1_vld", rx_valid, 1);
    chk("8n1_dat", rx_data, 8'hA5);
    chk("8n1_perr", rx_perr, 0);
    chk("8n1_ferr", rx_ferr, 0);
    chk("8n1_busy_done", busy, 0);
    pop_chk("8n1_pop", 8'hA5);
    chk("8n1_empty", rx_valid, 0);

    // 7E1 with parity bit 1 on 0x41 (two ones -> even parity 0): error
    data_len = 4'd7; pen = 1'b1; ohel = 1'b0;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("7e1_perr", rx_perr, 1);
    chk("7e1_ferr", rx_ferr, 0);
    pop_chk("7e1", 8'h41);

    // Same frame with odd parity: parity bit 1 is correct
    ohel = 1'b1;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("7o1_perr", rx_perr, 0);
    pop_chk("7o1", 8'h41);

    // 8O2, 0x3C (four ones -> odd parity bit 1), second stop 0; format changed mid-frame
    data_len = 4'd8; pen = 1'b1; ohel = 1'b1; two_stop = 1'b1;
    strobe(1'b0, 1'b0, 1'b0);
    data_len = 4'd5; pen = 1'b0; ohel = 1'b0; two_stop = 1'b0;
    for (int i = 0; i < 8; i++) strobe(words[0][0] ^ words[0][0] ^ (8'h3C >> i) & 1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("8o2_mid_busy", busy, 1);
    chk("8o2_mid_vld", rx_valid, 0);
    strobe(1'b0, 1'b0, 1'b0);
    chk("8o2_ferr", rx_ferr, 1);
    chk("8o2_perr", rx_perr, 0);
    chk("8o2_busy", busy, 0);
    pop_chk("8o2", 8'h3C);

    // data_len below 5 treated as 5
    data_len = 4'd3; pen = 1'b0; two_stop = 1'b0;
    send_frame(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("len3_busy", busy, 0);
    pop_chk("len3", 8'h15);

    // data_len above MAX_DATA_W treated as MAX_DATA_W
    data_len = 4'd15;
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("len15_busy", busy, 0);
    pop_chk("len15", 8'hC3);

    // Overrun: fill the output stage, then one more frame with clr_ovf on the commit edge
    data_len = 4'd8;
    for (int k = 0; k < HOLD; k++) frame8(words[k], 1'b0, 1'b0);
    chk("ovf_pre", overrun, 0);
    chk("ovf_pre_dat", rx_data, 8'h11);
    frame8(words[HOLD], 1'b0, 1'b1);
    chk("ovf_set_wins", overrun, 1);
    chk("ovf_head", rx_data, 8'h11);
    @(posedge clk); #1;
    chk("ovf_sticky", overrun, 1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("ovf_clr", overrun, 0);
    for (int k = 0; k < HOLD; k++) pop_chk("ovf_drain", words[k]);
    chk("ovf_empty", rx_valid, 0);

    // Same-edge pop and commit into a full stage
    for (int k = 0; k < HOLD; k++) frame8(words[k], 1'b0, 1'b0);
    frame8(words[HOLD], 1'b1, 1'b0);
    chk("same_edge_ovf", overrun, 0);
    chk("same_edge_head", rx_data, words[1]);
    for (int k = 1; k <= HOLD; k++) pop_chk("same_edge_drain", words[k]);
    chk("same_edge_empty", rx_valid, 0);

    // Reset mid-frame with a word held
    frame8(8'h5A, 1'b0, 1'b0);
    chk("rstmid_held", rx_valid, 1);
    strobe(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_vld", rx_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    frame8(8'h3C, 1'b0, 1'b0);
    chk("rstmid_ferr", rx_ferr, 0);
    pop_chk("rstmid_next", 8'h3C);
    chk("rstmid_ovf", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
